// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, valid/ready handshaked ALU for the 6502-style datapath.
//
// Purpose:
//   Takes two WIDTH-bit operands plus a mode code from the decoder stage and
//   returns a registered result with carry, overflow, zero and negative flags
//   to the accumulator/flags writeback stage. Binary operations complete one
//   cycle after accept and can stream back-to-back at one result per cycle.
//
// Optional feature (macro ALU_SEQ_BCD_EN):
//   When defined, ADD/SUB with `decimal` set take one extra cycle (ADJ state)
//   for a per-nibble BCD correction. When undefined, `decimal` is ignored and
//   every operation has latency 1.
//
// Parameters:
//   WIDTH            operand/result width (multiple of 4 when BCD is enabled)
//   DEFAULT_MODE_ADD 1: mode codes 9-15 act as ADD; 0: they return zero, flags clear
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/mode presented
//   in_ready   out  transaction accepted this cycle when in_valid is high
//   alu_a      in   operand A (only source for shifts/rotates)
//   alu_b      in   operand B
//   mode       in   0 ADD,1 AND,2 OR,3 XOR,4 SRS,5 SUB,6 ASL,7 ROL,8 ROR
//   carry_in   in   carry for ADD/SUB/ROL/ROR
//   decimal    in   BCD request for ADD/SUB
//   out_valid  out  result registered and valid
//   out_ready  in   consumer takes the result
//   alu_out    out  result
//   carry_out  out  carry / no-borrow / shifted-out bit
//   overflow   out  signed overflow
//   zero       out  alu_out == 0
//   negative   out  alu_out MSB
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH            = 8,
   parameter bit DEFAULT_MODE_ADD = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [3:0]       mode,
   input  logic             carry_in,
   input  logic             decimal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam logic [3:0] MODE_ADD = 4'd0;
   localparam logic [3:0] MODE_AND = 4'd1;
   localparam logic [3:0] MODE_OR  = 4'd2;
   localparam logic [3:0] MODE_XOR = 4'd3;
   localparam logic [3:0] MODE_SRS = 4'd4;
   localparam logic [3:0] MODE_SUB = 4'd5;
   localparam logic [3:0] MODE_ASL = 4'd6;
   localparam logic [3:0] MODE_ROL = 4'd7;
   localparam logic [3:0] MODE_ROR = 4'd8;

   localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef ALU_SEQ_BCD_EN
   localparam logic [1:0] ST_ADJ  = 2'd1;
`endif
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_alu_out;
   logic             r_carry;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   logic             w_accept;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;
   logic             w_sum_ovf;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_dec_req;

   assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == ST_DONE);
   assign alu_out   = r_alu_out;
   assign carry_out = r_carry;
   assign overflow  = r_ovf;
   assign zero      = r_zero;
   assign negative  = r_neg;

   // SUB is 6502 SBC: A + ~B + C, so carry out means "no borrow".
   assign w_b_eff   = (mode == MODE_SUB) ? ~alu_b : alu_b;
   assign w_sum     = {1'b0, alu_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, carry_in};
   assign w_sum_ovf = (alu_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                      (w_sum[WIDTH-1] != alu_a[WIDTH-1]);

   // Binary result for the currently presented operands.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (mode)
         MODE_ADD, MODE_SUB: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_sum_ovf;
         end
         MODE_AND: w_res = alu_a & alu_b;
         MODE_OR:  w_res = alu_a | alu_b;
         MODE_XOR: w_res = alu_a ^ alu_b;
         MODE_SRS: begin
            w_res = {1'b0, alu_a[WIDTH-1:1]};
            w_c   = alu_a[0];
         end
         MODE_ASL: begin
            w_res = {alu_a[WIDTH-2:0], 1'b0};
            w_c   = alu_a[WIDTH-1];
         end
         MODE_ROL: begin
            w_res = {alu_a[WIDTH-2:0], carry_in};
            w_c   = alu_a[WIDTH-1];
         end
         MODE_ROR: begin
            w_res = {carry_in, alu_a[WIDTH-1:1]};
            w_c   = alu_a[0];
         end
         default: begin
            // Unknown codes: either alias ADD (b_eff is plain B here) or
            // return zero with every flag clear.
            if (DEFAULT_MODE_ADD) begin
               w_res = w_sum[WIDTH-1:0];
               w_c   = w_sum[WIDTH];
               w_v   = w_sum_ovf;
            end
         end
      endcase
   end

`ifdef ALU_SEQ_BCD_EN
   // Operands captured on a decimal accept, consumed during ADJ.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_ci;
   logic             r_sub;
   logic             r_bin_ovf;
   logic [WIDTH:0]   w_bcd;

   assign w_dec_req = decimal & ((mode == MODE_ADD) | (mode == MODE_SUB));

   // Nibble-serial decimal add/subtract, LSB digit first. cy holds the
   // decimal carry for ADD and the decimal borrow for SUB. Returns {C, R}
   // where C is carry (ADD) or no-borrow (SUB).
   function automatic logic [WIDTH:0] f_bcd(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             ci,
                                            input logic             sub);
      logic             cy;
      logic [4:0]       s;
      logic [WIDTH-1:0] r;
      cy = sub ? ~ci : ci;
      r  = '0;
      for (int k = 0; k < WIDTH / 4; k++) begin
         if (!sub) begin
            s = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, cy};
            if (s > 5'd9) begin
               s  = s + 5'd6;
               cy = 1'b1;
            end else begin
               cy = 1'b0;
            end
         end else begin
            // Range is -10..15 for BCD digits, so bit 4 is the sign.
            s = {1'b0, a[4*k +: 4]} - {1'b0, b[4*k +: 4]} - {4'b0, cy};
            if (s[4]) begin
               s  = s - 5'd6;
               cy = 1'b1;
            end else begin
               cy = 1'b0;
            end
         end
         r[4*k +: 4] = s[3:0];
      end
      return {sub ? ~cy : cy, r};
   endfunction

   assign w_bcd = f_bcd(r_a, r_b, r_ci, r_sub);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_ci      <= 1'b0;
         r_sub     <= 1'b0;
         r_bin_ovf <= 1'b0;
      end else if (w_accept && w_dec_req) begin
         r_a       <= alu_a;
         r_b       <= alu_b;
         r_ci      <= carry_in;
         r_sub     <= (mode == MODE_SUB);
         r_bin_ovf <= w_sum_ovf;   // overflow reports the binary pre-adjust sum
      end
   end
`else
   logic w_unused_decimal;
   assign w_unused_decimal = decimal;
   assign w_dec_req        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_alu_out <= '0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
         r_zero    <= 1'b0;
         r_neg     <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_dec_req) begin
`ifdef ALU_SEQ_BCD_EN
               r_state <= ST_ADJ;
`endif
            end else begin
               r_state   <= ST_DONE;
               r_alu_out <= w_res;
               r_carry   <= w_c;
               r_ovf     <= w_v;
               r_zero    <= (w_res == '0);
               r_neg     <= w_res[WIDTH-1];
            end
         end else begin
            case (r_state)
`ifdef ALU_SEQ_BCD_EN
               ST_ADJ: begin
                  r_state   <= ST_DONE;
                  r_alu_out <= w_bcd[WIDTH-1:0];
                  r_carry   <= w_bcd[WIDTH];
                  r_ovf     <= r_bin_ovf;
                  r_zero    <= (w_bcd[WIDTH-1:0] == '0);
                  r_neg     <= w_bcd[WIDTH-1];
               end
`endif
               ST_DONE: begin
                  if (out_ready) begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_IDLE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked ALU for the 6502-style datapath; successor to the combinational 8-bit ALU.
- Generalised to WIDTH bits with a full mode set: add, subtract, logic ops, shifts and rotates.
- Produces real carry, overflow, zero and negative flags.
- Optional BCD (decimal) add/subtract taking one extra adjust cycle.
- Sits between the operand/decoder stage and the accumulator/flags writeback, using valid/ready on both sides.

Parameters:
- WIDTH, 8: operand and result width. Must be a multiple of 4 when BCD_EN is defined.
- DEFAULT_MODE_ADD, 1: 1 means unknown mode codes behave as ADD; 0 means they return all-zeros with all flags clear.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/mode presented
- in_ready  out  1  block accepts a transaction this cycle
- alu_a  in  WIDTH  operand A; sole source for shifts and rotates
- alu_b  in  WIDTH  operand B
- mode  in  4  0 ADD, 1 AND, 2 OR, 3 XOR, 4 SRS (logical shift right), 5 SUB, 6 ASL, 7 ROL, 8 ROR; 9-15 unknown
- carry_in  in  1  carry for ADD/SUB/ROL/ROR
- decimal  in  1  BCD request for ADD/SUB
- out_valid  out  1  result registered and valid
- out_ready  in  1  consumer takes the result
- alu_out  out  WIDTH  result
- carry_out  out  1  carry / no-borrow / shifted-out bit
- overflow  out  1  signed overflow
- zero  out  1  alu_out == 0
- negative  out  1  alu_out[WIDTH-1]

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0, alu_out=0, all flags 0. in_ready=1 once rst_n is high.
- FSM states:
  - IDLE: no result held.
  - ADJ: decimal adjust pending; exists only with BCD_EN.
  - DONE: result held.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is low in ADJ.
- Accept happens on in_valid & in_ready. Inputs are sampled on that edge and are don't-care otherwise.
- Transitions:
  - Binary op accepted: next state DONE, result registered on that edge. Latency is 1 (out_valid rises the cycle after accept).
  - Decimal ADD/SUB accepted (BCD_EN only): next state ADJ; then ADJ -> DONE on the next edge. Latency is 2.
  - DONE with out_ready and no new accept: next state IDLE.
  - DONE with out_ready and a new accept in the same cycle: back-to-back operation, one result per cycle for binary ops.
- While out_valid=1 and out_ready=0, alu_out and all flags are held stable.
- Arithmetic. Internal sum is WIDTH+1 bits.
  - ADD: {C,R} = A + B + carry_in.
  - SUB: {C,R} = A + ~B + carry_in (6502 SBC). C=1 means no borrow.
  - overflow (ADD/SUB) = sign(A)==sign(B') & sign(R)!=sign(A), where B' is B for ADD and ~B for SUB.
  - AND/OR/XOR: C=0, V=0.
  - SRS: R = A>>1, C = A[0].
  - ASL: R = A<<1, C = A[WIDTH-1].
  - ROL: R = {A[WIDTH-2:0], carry_in}, C = A[WIDTH-1].
  - ROR: R = {carry_in, A[WIDTH-1:1]}, C = A[0].
  - Shifts and rotates: V=0.
- zero and negative are always derived from the final registered alu_out, including after the decimal adjust.
- decimal is ignored for every mode other than ADD/SUB.
- Reset asserted mid-ADJ or mid-DONE: the pending result is discarded, out_valid drops immediately, and no stale result reappears.

Optional Feature:
- Macro: ALU_SEQ_BCD_EN.
- Defined:
  - Decimal ADD/SUB run a per-nibble BCD correction, LSB nibble first with the decimal carry chained, during ADJ.
  - ADD adds 6 to any nibble > 9 or with a nibble carry. SUB subtracts 6 on a nibble borrow.
  - carry_out is the decimal carry (ADD) or decimal no-borrow (SUB).
  - overflow is taken from the binary pre-adjust sum.
  - Results for non-BCD operand digits are unspecified but deterministic.
- Undefined:
  - The decimal input is ignored, the ADJ state does not exist, and all ops have latency 1.

Test Plan:
- Reset: rst_n low for 2 cycles while driving in_valid=1 -> out_valid=0, alu_out=0x00, all flags 0; then in_ready=1.
- ADD: A=0x50, B=0x50, ci=0, out_ready=1 -> 1 cycle later alu_out=0xA0, C=0, V=1, N=1, Z=0.
- SUB: A=0x00, B=0x01, ci=1 -> alu_out=0xFF, C=0, V=0, N=1. SUB A=0x05, B=0x05, ci=1 -> 0x00, C=1, Z=1.
- Decimal ADD (BCD_EN): A=0x58, B=0x46, ci=1 -> in_ready low for 1 cycle, out_valid 2 cycles after accept, alu_out=0x05, C=1. Without BCD_EN the same stimulus gives 0x9F after 1 cycle.
- Rotate and back-to-back: ROR A=0x01, ci=1 -> 0x80, C=1, N=1. Next cycle ASL A=0x81 -> 0x02, C=1. Throughput one result per cycle with out_ready=1.
- Backpressure and reset: hold out_ready=0 for 3 cycles after an XOR 0xFF^0x0F (result 0xF0) -> result stays 0xF0 and in_ready=0. Assert rst_n low during ADJ -> out_valid=0 at once and no result afterwards.
